// File: rtl/linescanner_pkg.sv
// Shared state encoding and default sizing for the line-scan acquisition scheduler.
package linescanner_pkg;

   localparam int DEF_PERIOD_W     = 16;
   localparam int DEF_LINES_W      = 16;
   localparam int DEF_PIX_W        = 12;
   localparam int DEF_LVAL_TIMEOUT = 4095;

   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_ARM         = 3'd1;
   localparam logic [2:0] ST_WAIT_LVAL   = 3'd2;
   localparam logic [2:0] ST_READOUT     = 3'd3;
   localparam logic [2:0] ST_WAIT_LOAD   = 3'd4;
   localparam logic [2:0] ST_WAIT_PERIOD = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE        = ST_IDLE,
      S_ARM         = ST_ARM,
      S_WAIT_LVAL   = ST_WAIT_LVAL,
      S_READOUT     = ST_READOUT,
      S_WAIT_LOAD   = ST_WAIT_LOAD,
      S_WAIT_PERIOD = ST_WAIT_PERIOD
   } state_t;

   // States in which a line is still in flight and the period may be overrun.
   function automatic logic is_line_active(input state_t s);
      return (s == S_WAIT_LVAL) || (s == S_READOUT) || (s == S_WAIT_LOAD);
   endfunction

endpackage

// File: rtl/linescanner_line_timer.sv
// Saturating line-period counter with synchronous clear and an expired flag.
module linescanner_line_timer #(
   parameter int W = 16
) (
   input  logic         pixel_clock,
   input  logic         n_reset,
   input  logic         clear,
   input  logic [W-1:0] limit,
   output logic [W-1:0] count,
   output logic         expired
);

   always_ff @(posedge pixel_clock or negedge n_reset) begin
      if (!n_reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count != '1) begin
         count <= count + W'(1);
      end
   end

   assign expired = (count >= limit);

endmodule

// File: rtl/linescanner_acquisition_scheduler.sv
// Arms the capture unit once per line period, tracks lval/load_pulse readout,
// counts pixels and lines per frame, and raises sticky timing/length errors.
module linescanner_acquisition_scheduler
   import linescanner_pkg::*;
#(
   parameter int PERIOD_W     = DEF_PERIOD_W,
   parameter int LINES_W      = DEF_LINES_W,
   parameter int PIX_W        = DEF_PIX_W,
   parameter int LVAL_TIMEOUT = DEF_LVAL_TIMEOUT
) (
   input  logic                pixel_clock,
   input  logic                n_reset,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   input  logic [PERIOD_W-1:0] line_period,
   input  logic [LINES_W-1:0]  lines_per_frame,
   input  logic [PIX_W-1:0]    pixels_per_line,
   input  logic                lval,
   input  logic                load_pulse,
   output logic                capture_enable,
   output logic                busy,
   output logic                line_start,
   output logic                line_done,
   output logic                frame_done,
   output logic [LINES_W-1:0]  line_index,
   output logic [PIX_W-1:0]    last_pixel_count,
   output logic                overrun_err,
   output logic                length_err,
   output logic                timeout_err
);

   localparam logic [31:0] TIMEOUT_LIM = 32'(LVAL_TIMEOUT);

   state_t state, state_next;

   logic                cap_en_reg, cap_en_next;
   logic                line_start_reg, line_start_next;
   logic                line_done_reg, line_done_next;
   logic                frame_done_reg, frame_done_next;
   logic [LINES_W-1:0]  line_index_reg, line_index_next;
   logic [PIX_W-1:0]    last_count_reg, last_count_next;
   logic [PIX_W-1:0]    pix_count_reg, pix_count_next;
   logic                overrun_reg, overrun_next;
   logic                length_reg, length_next;
   logic                timeout_reg, timeout_next;
   logic                stop_pend_reg, stop_pend_next;
   logic [LINES_W-1:0]  cfg_lines_reg, cfg_lines_next;
   logic [PIX_W-1:0]    cfg_pixels_reg, cfg_pixels_next;

   logic                timer_clear;
   logic [PERIOD_W-1:0] timer_count;
   logic [PERIOD_W-1:0] period_eff;
   logic [PERIOD_W-1:0] period_limit;
   logic [31:0]         timer_wide;
   logic                expired;
   logic                last_line;
   logic                advance;
   logic                stop_now;

   // Periods shorter than two cycles cannot fit ARM plus one wait cycle.
   assign period_eff   = (line_period < PERIOD_W'(2)) ? PERIOD_W'(2) : line_period;
   assign period_limit = period_eff - PERIOD_W'(1);
   assign timer_wide   = 32'(timer_count);
   assign last_line    = (line_index_reg == (cfg_lines_reg - LINES_W'(1)));

   linescanner_line_timer #(
      .W (PERIOD_W)
   ) u_line_timer (
      .pixel_clock (pixel_clock),
      .n_reset     (n_reset),
      .clear       (timer_clear),
      .limit       (period_limit),
      .count       (timer_count),
      .expired     (expired)
   );

   always_ff @(posedge pixel_clock or negedge n_reset) begin
      if (!n_reset) begin
         state          <= S_IDLE;
         cap_en_reg     <= 1'b0;
         line_start_reg <= 1'b0;
         line_done_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         line_index_reg <= '0;
         last_count_reg <= '0;
         pix_count_reg  <= '0;
         overrun_reg    <= 1'b0;
         length_reg     <= 1'b0;
         timeout_reg    <= 1'b0;
         stop_pend_reg  <= 1'b0;
         cfg_lines_reg  <= '0;
         cfg_pixels_reg <= '0;
      end else begin
         state          <= state_next;
         cap_en_reg     <= cap_en_next;
         line_start_reg <= line_start_next;
         line_done_reg  <= line_done_next;
         frame_done_reg <= frame_done_next;
         line_index_reg <= line_index_next;
         last_count_reg <= last_count_next;
         pix_count_reg  <= pix_count_next;
         overrun_reg    <= overrun_next;
         length_reg     <= length_next;
         timeout_reg    <= timeout_next;
         stop_pend_reg  <= stop_pend_next;
         cfg_lines_reg  <= cfg_lines_next;
         cfg_pixels_reg <= cfg_pixels_next;
      end
   end

   always_comb begin
      state_next      = state;
      cap_en_next     = cap_en_reg;
      line_start_next = 1'b0;
      line_done_next  = 1'b0;
      frame_done_next = 1'b0;
      line_index_next = line_index_reg;
      last_count_next = last_count_reg;
      pix_count_next  = pix_count_reg;
      overrun_next    = overrun_reg;
      length_next     = length_reg;
      timeout_next    = timeout_reg;
      stop_pend_next  = stop_pend_reg | (stop & (state != S_IDLE));
      cfg_lines_next  = cfg_lines_reg;
      cfg_pixels_next = cfg_pixels_reg;
      advance         = 1'b0;
      stop_now        = stop_pend_reg | stop;

      // A load strobe on the expiry cycle completes the line in time.
      if (is_line_active(state) && expired && !((state == S_WAIT_LOAD) && load_pulse))
         overrun_next = 1'b1;

      case (state)
         S_IDLE: begin
            if (start && !stop && (lines_per_frame != '0)) begin
               cfg_lines_next  = lines_per_frame;
               cfg_pixels_next = pixels_per_line;
               overrun_next    = 1'b0;
               length_next     = 1'b0;
               timeout_next    = 1'b0;
               line_index_next = '0;
               state_next      = S_ARM;
            end
         end
         S_ARM: begin
            cap_en_next     = 1'b1;
            line_start_next = 1'b1;
            pix_count_next  = '0;
            state_next      = S_WAIT_LVAL;
         end
         S_WAIT_LVAL: begin
            if (lval) begin
               cap_en_next    = 1'b0;
               pix_count_next = PIX_W'(1);
               state_next     = S_READOUT;
            end else if (timer_wide >= TIMEOUT_LIM) begin
               timeout_next = 1'b1;
               cap_en_next  = 1'b0;
               state_next   = S_IDLE;
            end
         end
         S_READOUT: begin
            if (lval) begin
               if (pix_count_reg == '1)
                  length_next = 1'b1;
               else
                  pix_count_next = pix_count_reg + PIX_W'(1);
            end else begin
               state_next = S_WAIT_LOAD;
            end
         end
         S_WAIT_LOAD: begin
            if (load_pulse) begin
               line_done_next  = 1'b1;
               last_count_next = pix_count_reg;
               if (pix_count_reg != cfg_pixels_reg)
                  length_next = 1'b1;
               // A late line re-arms immediately; the frame's last line still
               // passes through WAIT_PERIOD so frame_done trails line_done.
               if (expired && !last_line)
                  advance = 1'b1;
               else
                  state_next = S_WAIT_PERIOD;
            end
         end
         S_WAIT_PERIOD: begin
            if (expired) begin
               advance = 1'b1;
               if (last_line)
                  frame_done_next = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase

      if (advance) begin
         if (last_line) begin
            if (continuous && !stop_now && (lines_per_frame != '0)) begin
               cfg_lines_next  = lines_per_frame;
               cfg_pixels_next = pixels_per_line;
               line_index_next = '0;
               state_next      = S_ARM;
            end else begin
               state_next = S_IDLE;
            end
         end else if (stop_now) begin
            state_next = S_IDLE;
         end else begin
            line_index_next = line_index_reg + LINES_W'(1);
            state_next      = S_ARM;
         end
      end

      if (state_next == S_IDLE)
         stop_pend_next = 1'b0;

      timer_clear = (state_next == S_ARM);
   end

   assign capture_enable   = cap_en_reg;
   assign busy             = (state != S_IDLE);
   assign line_start       = line_start_reg;
   assign line_done        = line_done_reg;
   assign frame_done       = frame_done_reg;
   assign line_index       = line_index_reg;
   assign last_pixel_count = last_count_reg;
   assign overrun_err      = overrun_reg;
   assign length_err       = length_reg;
   assign timeout_err      = timeout_reg;

endmodule
